dav_rfd_averager: RTL and testbench

- Receiving end of the dav_/rfd byte handshake used by our producer blocks.
- Accepts 8-bit samples from an upstream producer and accumulates 2^LOG2N of them.
- Then drives their truncated mean to a downstream consumer over a second dav_/rfd pair, acting as producer on that side.
- Sits between a sample-producing unit and a slower consumer, decimating the data rate by 2^LOG2N.

---
 rtl/dav_rfd_averager.sv | 102 ++++++++++
 tb/tb_dav_rfd_averager.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dav_rfd_averager.sv
`default_nettype none
// ============================================================================
// dav_rfd_averager : mean of 2^LOG2N dav_/rfd samples, offered downstream.  Rev 1.0
// ============================================================================
module dav_rfd_averager #(
  parameter int LOG2N = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       dav_,
  output logic       rfd,
  input  logic [7:0] x,
  output logic [7:0] avg,
  output logic       dav_out_,
  input  logic       rfd_out
);

  localparam int ACC_W = 8 + LOG2N;
  localparam int CNT_W = LOG2N + 1;
  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(1 << LOG2N);

  typedef enum logic [1:0] {
    R0 = 2'd0,
    R1 = 2'd1,
    O0 = 2'd2,
    O1 = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             rfd_nx;
  logic             dav_out_nx;
  logic [7:0]       avg_nx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= R0;
      acc      <= '0;
      cnt      <= '0;
      rfd      <= 1'b1;
      dav_out_ <= 1'b1;
      avg      <= 8'd0;
    end else begin
      state    <= state_nx;
      acc      <= acc_nx;
      cnt      <= cnt_nx;
      rfd      <= rfd_nx;
      dav_out_ <= dav_out_nx;
      avg      <= avg_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    acc_nx     = acc;
    cnt_nx     = cnt;
    rfd_nx     = rfd;
    dav_out_nx = dav_out_;
    avg_nx     = avg;
    case (state)
      R0: begin
        if (!dav_) begin
          acc_nx   = acc + ACC_W'(x);
          cnt_nx   = cnt + CNT_W'(1);
          rfd_nx   = 1'b0;
          state_nx = R1;
        end
      end
      R1: begin
        // The window closes only once the producer has released dav_.
        if (dav_) begin
          if (cnt == N_CNT) begin
            avg_nx     = acc[LOG2N +: 8];
            dav_out_nx = 1'b0;
            state_nx   = O0;
          end else begin
            rfd_nx   = 1'b1;
            state_nx = R0;
          end
        end
      end
      O0: begin
        if (!rfd_out) begin
          dav_out_nx = 1'b1;
          state_nx   = O1;
        end
      end
      O1: begin
        if (rfd_out) begin
          acc_nx   = '0;
          cnt_nx   = '0;
          rfd_nx   = 1'b1;
          state_nx = R0;
        end
      end
      default: state_nx = R0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_dav_rfd_averager.sv
`default_nettype none
// Bench: two averagers (LOG2N=2 and LOG2N=0) driven by random handshakes,
// results checked against a window-sum model through per-instance scoreboards.
module tb_dav_rfd_averager;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] dav_n;
  logic [1:0] rfd_o;
  logic [1:0] davo_n;
  logic [1:0] rfdo;
  logic [7:0] xin [2];
  logic [7:0] avg_o [2];

  always #5 clock = ~clock;

  dav_rfd_averager #(.LOG2N(2)) dut_a (
    .clock(clock), .reset(reset), .dav_(dav_n[0]), .rfd(rfd_o[0]), .x(xin[0]),
    .avg(avg_o[0]), .dav_out_(davo_n[0]), .rfd_out(rfdo[0])
  );

  dav_rfd_averager #(.LOG2N(0)) dut_b (
    .clock(clock), .reset(reset), .dav_(dav_n[1]), .rfd(rfd_o[1]), .x(xin[1]),
    .avg(avg_o[1]), .dav_out_(davo_n[1]), .rfd_out(rfdo[1])
  );

  int checks   = 0;
  int failures = 0;
  int stall [2];
  int win_sum [2];
  int win_cnt [2];
  int win_n [2];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  // Reference: the mean of each completed window of win_n samples, truncated.
  task automatic model_sample(input int d, input int v);
    win_sum[d] += v;
    win_cnt[d]++;
    if (win_cnt[d] == win_n[d]) begin
      if (d == 0) q0.push_back(8'(win_sum[d] / win_n[d]));
      else        q1.push_back(8'(win_sum[d] / win_n[d]));
      win_sum[d] = 0;
      win_cnt[d] = 0;
    end
  endtask

  task automatic wait_rfd(input int d);
    int n = 0;
    while (rfd_o[d] !== 1'b1 && n < 400) begin
      @(negedge clock);
      n++;
    end
    check($sformatf("rfd_wait%0d", d), 32'(rfd_o[d]), 32'd1);
  endtask

  task automatic send(input int d, input int v, input int hold);
    wait_rfd(d);
    xin[d]  = 8'(v);
    dav_n[d] = 1'b0;
    model_sample(d, v);
    @(posedge clock);
    @(negedge clock);
    check($sformatf("rfd_fall%0d", d), 32'(rfd_o[d]), 32'd0);
    repeat (hold - 1) @(negedge clock);
    dav_n[d] = 1'b1;
    xin[d]  = 8'($urandom_range(0, 255));
  endtask

  task automatic drain(input int d);
    int n = 0;
    while ((qsize(d) != 0 || rfd_o[d] !== 1'b1) && n < 600) begin
      @(negedge clock);
      n++;
    end
    check($sformatf("drain_q%0d", d), 32'(qsize(d)), 32'd0);
  endtask

  task automatic monitor(input int d);
    logic       prev = 1'b1;
    logic [7:0] held = 8'd0;
    logic [7:0] exp_v;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev = 1'b1;
      end else begin
        if (prev === 1'b1 && davo_n[d] === 1'b0) begin
          if (qsize(d) == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result%0d actual=%0d required=none", d, avg_o[d]);
          end else begin
            exp_v = (d == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("avg%0d", d), 32'(avg_o[d]), 32'(exp_v));
          end
          held = avg_o[d];
        end else if (prev === 1'b0 && davo_n[d] === 1'b0) begin
          check($sformatf("avg_stable%0d", d), 32'(avg_o[d]), 32'(held));
        end
        prev = davo_n[d];
      end
    end
  endtask

  task automatic consumer(input int d);
    int n;
    forever begin
      @(negedge clock);
      if (!reset && davo_n[d] === 1'b0) begin
        repeat (stall[d]) @(negedge clock);
        rfdo[d] = 1'b0;
        n = 0;
        while (davo_n[d] !== 1'b1 && n < 100) begin
          @(negedge clock);
          n++;
        end
        check($sformatf("dav_out_release%0d", d), 32'(davo_n[d]), 32'd1);
        repeat ($urandom_range(0, 3)) @(negedge clock);
        rfdo[d] = 1'b1;
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial consumer(0);
  initial consumer(1);

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    win_n[0] = 4; win_n[1] = 1;
    win_sum[0] = 0; win_sum[1] = 0;
    win_cnt[0] = 0; win_cnt[1] = 0;
    stall[0] = 0; stall[1] = 0;
    reset = 1'b1;
    dav_n = 2'b11;
    rfdo  = 2'b11;
    xin[0] = 8'd0; xin[1] = 8'd0;
    #12;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_rfd%0d", d), 32'(rfd_o[d]), 32'd1);
      check($sformatf("reset_dav_out%0d", d), 32'(davo_n[d]), 32'd1);
      check($sformatf("reset_avg%0d", d), 32'(avg_o[d]), 32'd0);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Basic windows, saturation without wrap, and truncation.
    send(0, 10, 1); send(0, 20, 1); send(0, 30, 1); send(0, 40, 1);
    send(0, 255, 1); send(0, 255, 2); send(0, 255, 1); send(0, 255, 1);
    send(0, 1, 1); send(0, 1, 1); send(0, 1, 1); send(0, 2, 1);

    // Long dav_ pulses: one sample per pulse.
    for (int i = 0; i < 4; i++) send(0, int'($urandom_range(0, 255)), 6);

    // LOG2N=0 forwards every sample with its own handshake.
    send(1, 7, 1); send(1, 200, 2);
    drain(0);
    drain(1);

    // Downstream stall with an early upstream dav_.
    stall[0] = 10;
    send(0, 5, 1); send(0, 6, 1); send(0, 7, 1); send(0, 8, 1);
    n = 0;
    while (davo_n[0] !== 1'b0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("stall_dav_out_fell", 32'(davo_n[0]), 32'd0);
    xin[0] = 8'd99;
    dav_n[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("stall_rfd_low", 32'(rfd_o[0]), 32'd0);
      check("stall_dav_out_low", 32'(davo_n[0]), 32'd0);
    end
    model_sample(0, 99);
    wait_rfd(0);
    @(negedge clock);
    check("late_capture_rfd", 32'(rfd_o[0]), 32'd0);
    dav_n[0] = 1'b1;
    stall[0] = 0;
    send(0, 1, 1); send(0, 2, 1); send(0, 3, 1);
    drain(0);

    // Reset with a partial window pending.
    send(0, 10, 1); send(0, 20, 1);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("midreset_rfd%0d", d), 32'(rfd_o[d]), 32'd1);
      check($sformatf("midreset_dav_out%0d", d), 32'(davo_n[d]), 32'd1);
      check($sformatf("midreset_avg%0d", d), 32'(avg_o[d]), 32'd0);
      win_sum[d] = 0;
      win_cnt[d] = 0;
    end
    @(negedge clock);
    #2;
    reset = 1'b0;
    @(negedge clock);
    send(0, 8, 1); send(0, 8, 1); send(0, 8, 1); send(0, 8, 1);
    drain(0);

    // Randomised traffic on both instances.
    for (int i = 0; i < 32; i++) begin
      if (i % 4 == 0) stall[0] = int'($urandom_range(0, 4));
      send(0, int'($urandom_range(0, 255)), int'($urandom_range(1, 4)));
    end
    for (int i = 0; i < 10; i++) begin
      stall[1] = int'($urandom_range(0, 3));
      send(1, int'($urandom_range(0, 255)), int'($urandom_range(1, 3)));
    end
    drain(0);
    drain(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
